// File: rtl/serial_byte_loader_if.sv
// Handshake and byte-memory bus for serial_byte_loader.
// master = serial source / memory side, slave = the loader.
interface serial_byte_loader_if;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [7:0] data;
    logic       store;
    logic       busy;
    logic       done;
    logic       parity_err;

    modport master (
        output start, bit_in, bit_valid,
        input  bit_ready, data, store, busy, done, parity_err
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output bit_ready, data, store, busy, done, parity_err
    );
endinterface

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel loader feeding an 8-bit latch store; data is registered and frozen around store.
// Optional even-parity 9th bit is enabled with `define SERIAL_PARITY_EN.
module serial_byte_loader #(
    parameter bit          MSB_FIRST    = 1'b1,
    parameter int unsigned STORE_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset,
    serial_byte_loader_if.slave bus
);

`ifdef SERIAL_PARITY_EN
    typedef enum logic [2:0] {IDLE, SHIFT, PARITY, LOAD, STROBE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, STROBE} state_t;
`endif

    localparam logic [3:0] STROBE_LAST = 4'(STORE_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] strobe_cnt_q, strobe_cnt_d;
    logic       store_q, store_d;
    logic       done_q, done_d;
    logic [7:0] shift_next;
`ifdef SERIAL_PARITY_EN
    logic       perr_q, perr_d;
`endif

    assign shift_next = MSB_FIRST ? {shift_q[6:0], bus.bit_in}
                                  : {bus.bit_in, shift_q[7:1]};

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        data_d       = data_q;
        bit_cnt_d    = bit_cnt_q;
        strobe_cnt_d = strobe_cnt_q;
        store_d      = 1'b0;
        done_d       = 1'b0;
`ifdef SERIAL_PARITY_EN
        perr_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SHIFT;
                    shift_d   = 8'h00;
                    bit_cnt_d = 4'd0;
                end
            end
            SHIFT: begin
                if (bus.bit_valid) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
`ifdef SERIAL_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = LOAD;
`endif
                    end
                end
            end
`ifdef SERIAL_PARITY_EN
            PARITY: begin
                if (bus.bit_valid) begin
                    if (^{shift_q, bus.bit_in}) begin
                        state_d = IDLE;
                        perr_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
`endif
            LOAD: begin
                data_d       = shift_q;
                strobe_cnt_d = 4'd0;
                state_d      = STROBE;
            end
            STROBE: begin
                // First STROBE cycle keeps store low so data has a full cycle of setup.
                if (strobe_cnt_q == STROBE_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    store_d      = 1'b1;
                    strobe_cnt_d = strobe_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            bit_cnt_q    <= 4'd0;
            strobe_cnt_q <= 4'd0;
            store_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            bit_cnt_q    <= bit_cnt_d;
            strobe_cnt_q <= strobe_cnt_d;
            store_q      <= store_d;
            done_q       <= done_d;
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= perr_d;
    end

    assign bus.parity_err = perr_q;
    assign bus.bit_ready  = (state_q == SHIFT) || (state_q == PARITY);
`else
    assign bus.parity_err = 1'b0;
    assign bus.bit_ready  = (state_q == SHIFT);
`endif

    assign bus.data  = data_q;
    assign bus.store = store_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader: MSB-first and LSB-first instances share one bit stream,
// a scoreboard holds the byte each instance must present when store rises.
module tb_serial_byte_loader;

    logic clk = 1'b0;
    logic reset;
    logic start, bit_in, bit_valid;

    always #5 clk = ~clk;

    serial_byte_loader_if if_m ();
    serial_byte_loader_if if_l ();

    assign if_m.start     = start;
    assign if_m.bit_in    = bit_in;
    assign if_m.bit_valid = bit_valid;
    assign if_l.start     = start;
    assign if_l.bit_in    = bit_in;
    assign if_l.bit_valid = bit_valid;

    serial_byte_loader #(.MSB_FIRST(1'b1), .STORE_CYCLES(2)) u_dut_msb (
        .clk(clk), .reset(reset), .bus(if_m)
    );
    serial_byte_loader #(.MSB_FIRST(1'b0), .STORE_CYCLES(2)) u_dut_lsb (
        .clk(clk), .reset(reset), .bus(if_l)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: index 0 = MSB-first instance, 1 = LSB-first instance
    logic [7:0] exp_q[2][$];

    logic [1:0] st_v, dn_v, pe_v;
    logic [7:0] dv[2];
    assign st_v  = {if_l.store, if_m.store};
    assign dn_v  = {if_l.done, if_m.done};
    assign pe_v  = {if_l.parity_err, if_m.parity_err};
    assign dv[0] = if_m.data;
    assign dv[1] = if_l.data;

    logic [1:0] prev_st = 2'b00;
    logic [7:0] prev_d[2] = '{8'h00, 8'h00};
    logic [7:0] hold_d[2] = '{8'h00, 8'h00};
    int         slen[2]   = '{0, 0};
    int         n_perr[2] = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (st_v[k] && !prev_st[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk("unexpected_store", {31'd0, st_v[k]}, 32'd0);
                end else begin
                    chk("store_data", {24'd0, dv[k]}, {24'd0, exp_q[k].pop_front()});
                end
                chk("data_setup", {24'd0, dv[k]}, {24'd0, prev_d[k]});
                hold_d[k] <= dv[k];
                slen[k]   <= 1;
            end else if (st_v[k] && prev_st[k]) begin
                chk("data_hold", {24'd0, dv[k]}, {24'd0, hold_d[k]});
                slen[k] <= slen[k] + 1;
            end
            if (!st_v[k] && prev_st[k]) begin
                chk("store_len", slen[k], 32'd2);
                chk("done_after_store", {31'd0, dn_v[k]}, 32'd1);
            end
            if (dn_v[k] && (st_v[k] || !prev_st[k]))
                chk("stray_done", {31'd0, dn_v[k]}, 32'd0);
            if (pe_v[k]) n_perr[k] <= n_perr[k] + 1;
            prev_st[k] <= st_v[k];
            prev_d[k]  <= dv[k];
        end
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // seq[7] is the first bit on the wire; returns at the negedge after done is expected.
    task automatic send_byte(input logic [7:0] seq, input int gap, input bit stray);
        exp_q[0].push_back(seq);
        exp_q[1].push_back(rev8(seq));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_in    = seq[7-i];
            bit_valid = 1'b1;
            @(negedge clk);
            bit_valid = 1'b0;
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    start = stray && (g == 0);
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
`ifdef SERIAL_PARITY_EN
        bit_in    = ^seq;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
`endif
        chk("load_store_low", {31'd0, if_m.store}, 32'd0);
        @(negedge clk);
        chk("data_msb", {24'd0, if_m.data}, {24'd0, seq});
        chk("data_lsb", {24'd0, if_l.data}, {24'd0, rev8(seq)});
        chk("store_pre", {31'd0, if_m.store}, 32'd0);
        @(negedge clk);
        chk("store_rise", {30'd0, st_v}, 32'd3);
        @(negedge clk);
        chk("store_hold", {30'd0, st_v}, 32'd3);
        @(negedge clk);
        chk("store_fall", {30'd0, st_v}, 32'd0);
        chk("done_pulse", {30'd0, dn_v}, 32'd3);
        chk("busy_idle", {31'd0, if_m.busy}, 32'd0);
    endtask

`ifdef SERIAL_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] seq);
        logic [7:0] old_m, old_l;
        old_m = if_m.data;
        old_l = if_l.data;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bit_in    = (i < 8) ? seq[7-i] : ~(^seq);
            bit_valid = 1'b1;
            @(negedge clk);
            bit_valid = 1'b0;
        end
        chk("perr_pulse", {30'd0, pe_v}, 32'd3);
        chk("perr_busy", {31'd0, if_m.busy}, 32'd0);
        @(negedge clk);
        chk("perr_single", {30'd0, pe_v}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("perr_no_store", {30'd0, st_v}, 32'd0);
        end
        chk("perr_data_msb", {24'd0, if_m.data}, {24'd0, old_m});
        chk("perr_data_lsb", {24'd0, if_l.data}, {24'd0, old_l});
    endtask
`endif

    initial begin
        int exp_perr;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        reset     = 1'b1;
        exp_perr  = 0;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, if_m.data}, 32'd0);
        chk("rst_ready", {31'd0, if_m.bit_ready}, 32'd0);
        chk("rst_perr", {31'd0, if_m.parity_err}, 32'd0);
        reset = 1'b0;

        repeat (10) begin
            @(negedge clk);
            chk("idle_data", {24'd0, if_m.data}, 32'd0);
            chk("idle_store", {31'd0, if_m.store}, 32'd0);
            chk("idle_busy", {31'd0, if_m.busy}, 32'd0);
            chk("idle_done", {31'd0, if_m.done}, 32'd0);
        end

        // A5 gapless, then C0 started in the same cycle as the previous done
        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'hC0, 0, 1'b0);
        // bit_valid gaps with stray start pulses mid-byte
        send_byte(8'hC0, 3, 1'b1);
        send_byte(8'h5A, 1, 1'b1);

        // reset after 5 bits discards the partial byte and clears data
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_in    = i[0];
            bit_valid = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        chk("mid_ready", {31'd0, if_m.bit_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_data_m", {24'd0, if_m.data}, 32'd0);
        chk("mid_rst_data_l", {24'd0, if_l.data}, 32'd0);
        chk("mid_rst_busy", {31'd0, if_m.busy}, 32'd0);
        repeat (3) @(negedge clk);
        send_byte(8'h3C, 0, 1'b0);

`ifdef SERIAL_PARITY_EN
        send_byte(8'h0F, 0, 1'b0);
        send_bad_parity(8'h0F);
        exp_perr = 1;
`endif

        repeat (5) @(negedge clk);
        chk("sb_empty_msb", exp_q[0].size(), 32'd0);
        chk("sb_empty_lsb", exp_q[1].size(), 32'd0);
        chk("perr_count_msb", n_perr[0], exp_perr);
        chk("perr_count_lsb", n_perr[1], exp_perr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/serial_byte_loader.md
# serial_byte_loader

Serial-to-parallel front end for the 8-bit latch store. Collects one byte from a serial bit stream under a valid/ready handshake and presents it on `data`. It then drives `store` so the downstream byte memory latches the byte. `data` is registered and changes only while `store` is low, which gives the level-sensitive latches setup and hold margin on both sides of the enable pulse.

## Interface
- `MSB_FIRST`, default 1: 1 = first accepted bit lands in `data[7]`; 0 = first accepted bit lands in `data[0]`.
- `STORE_CYCLES`, default 2: width of the `store` pulse in clock cycles. Legal range 1..15.

Ports:
- `clk`  in  1  Single clock; all flops on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `start`  in  1  Begin a byte. Sampled only in IDLE.
- `bit_in`  in  1  Serial data bit.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_ready`  out  1  Loader accepts a bit this cycle. High only in SHIFT.
- `data`  out  8  Assembled byte. Connects to the byte memory data input.
- `store`  out  1  Latch enable. Connects to the byte memory store input.
- `busy`  out  1  High in every state except IDLE.
- `done`  out  1  One-cycle pulse when a byte has been stored.
- `parity_err`  out  1  One-cycle pulse on a parity mismatch. Tied 0 when parity is compiled out.

## Operation
- States: IDLE, SHIFT, LOAD, STROBE (plus PARITY when compiled in).
- IDLE:
  - `start`=1 moves to SHIFT and clears the internal shift register and bit counter (4 bits).
  - `bit_valid` is ignored.
- SHIFT:
  - A bit is accepted on each edge where `bit_valid`=1.
  - MSB_FIRST=1 shifts left, inserting at bit 0. MSB_FIRST=0 shifts right, inserting at bit 7.
  - The counter increments by 1 per accepted bit. Cycles without `bit_valid` are stalls with unlimited length.
  - The 8th accepted bit moves to LOAD (or PARITY when compiled in).
- LOAD: `data` <= shift register. `store` stays 0. Next state is STROBE.
- STROBE:
  - `store`=1 for exactly STORE_CYCLES cycles, then return to IDLE.
  - `done`=1 for the first IDLE cycle.
- `data` holds its value until the next LOAD. It never changes while `store`=1.
- `start` outside IDLE is ignored. It is not queued.
- `start` asserted in the same cycle that `done` is high is honored.

## Timing
- Reset values: state IDLE, `data`=8'h00, `store`=0, `busy`=0, `done`=0, `parity_err`=0, `bit_ready`=0, counter 0.
- `start` is sampled at edge T0. SHIFT begins at T0+1, and `bit_ready` is high from T0+1.
- 8th bit accepted at edge N:
  - LOAD is active during cycle N..N+1, and `data` updates at edge N+1.
  - `store` is high from edge N+2 through edge N+2+STORE_CYCLES.
  - `done` is high for one cycle starting at edge N+2+STORE_CYCLES.
- `data` is therefore stable 1 cycle before `store` rises and stays stable indefinitely after `store` falls.
- Minimum byte time with back-to-back bits: 1 + 8 + 1 + STORE_CYCLES cycles.
- Reset mid-byte: partial bits are discarded and `data` is cleared to 0.
- Reset during STROBE: `store` drops at the reset edge, and `done` is not pulsed.

## Configuration
- `SERIAL_PARITY_EN` defined:
  - After 8 data bits, the FSM enters PARITY with `bit_ready`=1 and accepts one more bit.
  - Even parity: XOR of the 8 data bits and the parity bit must be 0.
  - Match → LOAD, with unchanged timing shifted by one accepted bit.
  - Mismatch → IDLE with `parity_err`=1 for one cycle. No LOAD and no `store`; `data` keeps its previous value.
- `SERIAL_PARITY_EN` undefined: no PARITY state, no 9th bit, and `parity_err` is constant 0.

## Test plan
- Reset then idle for 10 cycles → `data`=00, `store`=0, `busy`=0, `done`=0 throughout.
- MSB_FIRST=1, start, bits 1,0,1,0,0,1,0,1 back-to-back → `data`=A5 one cycle before `store`. `store` is high 2 cycles, then a single `done` pulse.
- MSB_FIRST=0 with the same bits → `data`=A5 bit-reversed = A5 (palindrome). Then send 1,1,0,0,0,0,0,0 → `data`=03.
- Bits with 3-cycle `bit_valid` gaps plus stray `start` pulses mid-byte → same `data` as the gapless case, with no restart.
- Reset asserted after 5 bits, then a fresh byte 3C → no `store` before the new byte, then `data`=3C.
- Parity compiled in: byte 0F with parity bit 0 → stored. Byte 0F with parity bit 1 → `parity_err` pulse, no `store`, `data` stays 0F.
